// File: rtl/tx_fifo_buffer.sv
// Transmit FIFO between the host register interface and the UART shift engine.
// Circular queue with registered read data, occupancy-based status and sticky error flags.
module tx_fifo_buffer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int AFULL_LVL = 12
) (
    input  logic             tClk,
    input  logic             tRst,
    input  logic             tWR,
    input  logic [WIDTH-1:0] tdataIn,
    input  logic             tRD,
    output logic [WIDTH-1:0] tdataOut,
    output logic             tdataValid,
    output logic             tEMPTY,
    output logic             tFULL,
    output logic             tAFULL,
    output logic             ttxrdy,
    output logic [AW:0]      tcount,
    input  logic             tClrErr,
    output logic             tOVF,
    output logic             tUDF
);

    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];
    localparam logic [AW:0] AFULL_CNT = AFULL_LVL[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_data_out;
    logic             r_data_valid;
    logic             r_ovf;
    logic             r_udf;

    logic w_empty;
    logic w_full;
    logic w_rd_ok;
    logic w_wr_ok;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_CNT);
    assign w_rd_ok = tRD & ~w_empty;
    // A read frees the head slot in the same cycle, so a full FIFO still takes a paired write.
    assign w_wr_ok = tWR & (~w_full | w_rd_ok);

    // NOTE: storage has no reset; stale contents are unreachable once the pointers are zeroed.
    always_ff @(posedge tClk) begin
        if (w_wr_ok && !tRst) begin
            r_mem[r_wr_ptr] <= tdataIn;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge tClk) begin
        if (tRst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_ovf        <= 1'b0;
            r_udf        <= 1'b0;
        end else begin
            r_data_valid <= w_rd_ok;
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_data_out <= r_mem[r_rd_ptr];
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A fresh error event outranks a coincident clear.
            if (tWR && !w_wr_ok) begin
                r_ovf <= 1'b1;
            end else if (tClrErr) begin
                r_ovf <= 1'b0;
            end
            if (tRD && !w_rd_ok) begin
                r_udf <= 1'b1;
            end else if (tClrErr) begin
                r_udf <= 1'b0;
            end
        end
    end

    assign tdataOut   = r_data_out;
    assign tdataValid = r_data_valid;
    assign tcount     = r_count;
    assign tEMPTY     = w_empty;
    assign tFULL      = w_full;
    assign tAFULL     = (r_count >= AFULL_CNT);
    assign ttxrdy     = ~w_full & ~tRst;
    assign tOVF       = r_ovf;
    assign tUDF       = r_udf;

endmodule

// File: tb/tb_tx_fifo_buffer.sv
// Self-checking bench for tx_fifo_buffer: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_tx_fifo_buffer;

    localparam int DEPTH = 16;

    logic       tClk;
    logic       tRst;
    logic       tWR;
    logic [7:0] tdataIn;
    logic       tRD;
    logic [7:0] tdataOut;
    logic       tdataValid;
    logic       tEMPTY;
    logic       tFULL;
    logic       tAFULL;
    logic       ttxrdy;
    logic [4:0] tcount;
    logic       tClrErr;
    logic       tOVF;
    logic       tUDF;

    tx_fifo_buffer #(
        .WIDTH(8), .DEPTH(DEPTH), .AW(4), .AFULL_LVL(12)
    ) dut (
        .tClk(tClk), .tRst(tRst), .tWR(tWR), .tdataIn(tdataIn), .tRD(tRD),
        .tdataOut(tdataOut), .tdataValid(tdataValid), .tEMPTY(tEMPTY),
        .tFULL(tFULL), .tAFULL(tAFULL), .ttxrdy(ttxrdy), .tcount(tcount),
        .tClrErr(tClrErr), .tOVF(tOVF), .tUDF(tUDF)
    );

    initial tClk = 1'b0;
    always #5 tClk = ~tClk;

    int checks = 0;
    int errors = 0;

    // Reference model: the FIFO as a plain queue plus the visible output registers.
    logic [7:0] q[$];
    logic [7:0] m_out;
    logic       m_valid;
    logic       m_ovf;
    logic       m_udf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input logic rst);
        check("count",  32'(tcount), q.size());
        check("empty",  32'(tEMPTY), 32'(q.size() == 0));
        check("full",   32'(tFULL),  32'(q.size() == DEPTH));
        check("afull",  32'(tAFULL), 32'(q.size() >= 12));
        check("txrdy",  32'(ttxrdy), 32'(q.size() != DEPTH && !rst));
        check("valid",  32'(tdataValid), 32'(m_valid));
        check("dout",   32'(tdataOut),   32'(m_out));
        check("ovf",    32'(tOVF), 32'(m_ovf));
        check("udf",    32'(tUDF), 32'(m_udf));
    endtask

    // Apply one cycle of requests, advance the model by the FIFO rules, then compare.
    task automatic cycle(input logic wr, input logic [7:0] din, input logic rd,
                         input logic clr, input logic rst);
        bit full, empty, rd_ok, wr_ok;
        tWR = wr; tdataIn = din; tRD = rd; tClrErr = clr; tRst = rst;
        @(posedge tClk);
        if (rst) begin
            q.delete();
            m_out = 8'h00; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            full  = (q.size() == DEPTH);
            empty = (q.size() == 0);
            rd_ok = rd && !empty;
            wr_ok = wr && (!full || rd_ok);
            m_valid = rd_ok;
            if (rd_ok) m_out = q.pop_front();
            if (wr_ok) q.push_back(din);
            if (wr && !wr_ok) m_ovf = 1'b1;
            else if (clr)     m_ovf = 1'b0;
            if (rd && !rd_ok) m_udf = 1'b1;
            else if (clr)     m_udf = 1'b0;
        end
        #1;
        compare_all(rst);
    endtask

    initial begin
        logic [7:0] d;
        tRst = 1'b1; tWR = 1'b0; tRD = 1'b0; tClrErr = 1'b0; tdataIn = 8'h00;
        m_out = 8'h00; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;

        // Reset, then release with no requests.
        cycle(0, 8'h00, 0, 0, 1);
        cycle(0, 8'h00, 0, 0, 1);
        cycle(0, 8'h00, 0, 0, 0);
        check("rel_txrdy", 32'(ttxrdy), 32'd1);
        check("rel_dout",  32'(tdataOut), 32'h00);

        // Three writes then three reads, in order.
        cycle(1, 8'h11, 0, 0, 0);
        cycle(1, 8'h22, 0, 0, 0);
        cycle(1, 8'h33, 0, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        check("rd1", 32'(tdataOut), 32'h11);
        cycle(0, 8'h00, 1, 0, 0);
        check("rd2", 32'(tdataOut), 32'h22);
        cycle(0, 8'h00, 1, 0, 0);
        check("rd3", 32'(tdataOut), 32'h33);
        check("rd3_valid", 32'(tdataValid), 32'd1);
        check("rd3_empty", 32'(tEMPTY), 32'd1);

        // Fill to full, overflow, drain.
        for (int i = 0; i < 16; i++) begin
            cycle(1, 8'(i), 0, 0, 0);
            check("fill_afull", 32'(tAFULL), 32'((i + 1) >= 12));
        end
        check("fill_full",  32'(tFULL),  32'd1);
        check("fill_txrdy", 32'(ttxrdy), 32'd0);
        cycle(1, 8'hAA, 0, 0, 0);
        check("ovf_set",   32'(tOVF),   32'd1);
        check("ovf_count", 32'(tcount), 32'd16);
        for (int i = 0; i < 16; i++) begin
            cycle(0, 8'h00, 1, 0, 0);
            check("drain", 32'(tdataOut), 32'(i));
        end
        cycle(0, 8'h00, 0, 1, 0);
        check("ovf_clr", 32'(tOVF), 32'd0);

        // Simultaneous write and read while full.
        for (int i = 0; i < 16; i++) cycle(1, 8'(8'h20 + i), 0, 0, 0);
        cycle(1, 8'h55, 1, 0, 0);
        check("full_rw_head",  32'(tdataOut), 32'h20);
        check("full_rw_count", 32'(tcount),   32'd16);
        check("full_rw_ovf",   32'(tOVF),     32'd0);
        for (int i = 0; i < 16; i++) cycle(0, 8'h00, 1, 0, 0);
        check("full_rw_last", 32'(tdataOut), 32'h55);

        // Simultaneous write and read while empty: no bypass.
        cycle(1, 8'h77, 1, 0, 0);
        check("empty_rw_udf",   32'(tUDF),       32'd1);
        check("empty_rw_valid", 32'(tdataValid), 32'd0);
        check("empty_rw_count", 32'(tcount),     32'd1);
        cycle(0, 8'h00, 1, 0, 0);
        check("empty_rw_data", 32'(tdataOut), 32'h77);
        cycle(0, 8'h00, 0, 1, 0);
        check("udf_clr", 32'(tUDF), 32'd0);

        // Set-wins: clear coincident with a new underflow keeps the flag.
        cycle(0, 8'h00, 1, 1, 0);
        check("udf_setwins", 32'(tUDF), 32'd1);
        cycle(0, 8'h00, 0, 1, 0);

        // Interleaved write/read pairs wrap both pointers.
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            cycle(1, d, 0, 0, 0);
            cycle(0, 8'h00, 1, 0, 0);
            check("wrap_data", 32'(tdataOut), 32'(d));
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 60, 8'($urandom),
                  $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 5, 1'b0);
        end

        // Drain, load five words, then reset mid-operation.
        for (int i = 0; i < DEPTH && q.size() > 0; i++) cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, 8'(8'hC0 + i), 0, 0, 0);
        check("pre_rst_count", 32'(tcount), 32'd5);
        cycle(1, 8'hEE, 1, 0, 1);
        check("rst_count", 32'(tcount),     32'd0);
        check("rst_empty", 32'(tEMPTY),     32'd1);
        check("rst_valid", 32'(tdataValid), 32'd0);
        cycle(0, 8'h00, 1, 0, 0);
        check("post_rst_udf", 32'(tUDF), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
